razor_error_ctrl: RTL and testbench

- Consumer end of the Razor error interface: takes the per-bit error flags from the razor_clk_only result-register cells and drives pipeline recovery (restore, stall, replay).
- Also keeps error statistics and issues voltage up/down requests to the supply controller over a valid/ack handshake.
- Sits beside the ALU result register, between the Razor cells and the pipeline control/DVS logic.

---
 rtl/razor_pkg.sv | 24 ++
 rtl/razor_dvs_window.sv | 62 ++++++
 rtl/razor_error_ctrl.sv | 115 +++++++++++
 tb/tb_razor_error_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/razor_pkg.sv
// Shared types and defaults for the Razor error consumer and its razor_clk_only integration.
package razor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        STALL   = 2'd2,
        REPLAY  = 2'd3
    } razor_state_e;

    localparam logic VDD_UP   = 1'b1;
    localparam logic VDD_DOWN = 1'b0;

    localparam int unsigned DEF_WIDTH          = 32;
    localparam int unsigned DEF_RECOVER_CYCLES = 1;
    localparam int unsigned DEF_WINDOW         = 256;
    localparam int unsigned DEF_HI_THRESH      = 4;
    localparam int unsigned DEF_LO_THRESH      = 0;
    localparam int unsigned DEF_CNT_W          = 16;

    // Per-window error tally width; the tally saturates at its maximum.
    localparam int unsigned WIN_ERR_W = 8;

endpackage

// File: rtl/razor_dvs_window.sv
// DVS sampling window: counts accepted errors per window and raises voltage
// up/down requests to the supply controller over a valid/ack handshake.
module razor_dvs_window
    import razor_pkg::*;
#(
    parameter int unsigned WINDOW    = DEF_WINDOW,
    parameter int unsigned HI_THRESH = DEF_HI_THRESH,
    parameter int unsigned LO_THRESH = DEF_LO_THRESH
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  logic vdd_ack,
    output logic vdd_req_valid,
    output logic vdd_req_up
);

    localparam int unsigned WIN_W = $clog2(WINDOW);

    logic [WIN_W-1:0]     win_cnt;
    logic [WIN_ERR_W-1:0] win_err;
    logic [WIN_ERR_W:0]   total;
    logic                 win_end;
    logic                 dec_up;
    logic                 dec_down;
    logic                 load;

    assign win_end  = (win_cnt == WIN_W'(WINDOW - 1));
    // The accept arriving on the closing edge still belongs to this window.
    assign total    = {1'b0, win_err} + {{WIN_ERR_W{1'b0}}, accept};
    assign dec_up   = win_end && (32'(total) >= HI_THRESH);
    assign dec_down = win_end && (32'(total) <= LO_THRESH);
    assign load     = (dec_up || dec_down) && (!vdd_req_valid || vdd_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt <= '0;
            win_err <= '0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (win_end) begin
                win_err <= '0;
            end else if (accept && (win_err != '1)) begin
                win_err <= win_err + WIN_ERR_W'(1);
            end
        end
    end

    // A decision that finds a request still pending (and not being acked) is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vdd_req_valid <= 1'b0;
            vdd_req_up    <= 1'b0;
        end else if (load) begin
            vdd_req_valid <= 1'b1;
            vdd_req_up    <= dec_up ? VDD_UP : VDD_DOWN;
        end else if (vdd_ack) begin
            vdd_req_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/razor_error_ctrl.sv
// Razor error consumer: drives restore/stall/replay recovery from per-bit error
// flags, keeps error statistics and feeds the DVS request window.
//
//   state   | meaning
//   IDLE    | waiting for an accepted error
//   RESTORE | shadow latch value copied into main flops, pipeline stalled
//   STALL   | pipeline held for RECOVER_CYCLES cycles
//   REPLAY  | one-cycle re-issue of the stalled operation
module razor_error_ctrl
    import razor_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int unsigned WINDOW         = DEF_WINDOW,
    parameter int unsigned HI_THRESH      = DEF_HI_THRESH,
    parameter int unsigned LO_THRESH      = DEF_LO_THRESH,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] err_in,
    input  logic             valid_in,
    input  logic             clr_count,
    input  logic             vdd_ack,
    output logic             restore,
    output logic             stall,
    output logic             replay,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic             vdd_req_valid,
    output logic             vdd_req_up
);

    localparam int unsigned RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    razor_state_e    state;
    razor_state_e    state_nxt;
    logic [RC_W-1:0] rc_cnt;
    logic            accept;

    assign accept = valid_in && (|err_in) && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Loaded while in RESTORE so it holds RECOVER_CYCLES-1 on the first STALL cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rc_cnt <= '0;
        end else if (state == RESTORE) begin
            rc_cnt <= RC_W'(RECOVER_CYCLES - 1);
        end else if ((state == STALL) && (rc_cnt != '0)) begin
            rc_cnt <= rc_cnt - RC_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        restore   = 1'b0;
        stall     = 1'b0;
        replay    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RESTORE;
            end
            RESTORE: begin
                restore   = 1'b1;
                stall     = 1'b1;
                state_nxt = STALL;
            end
            STALL: begin
                stall = 1'b1;
                if (rc_cnt == '0) state_nxt = REPLAY;
            end
            REPLAY: begin
                replay    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear wins first, then a same-cycle accept still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr_count) begin
            err_count  <= accept ? CNT_W'(1) : '0;
            err_sticky <= accept;
        end else if (accept) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            err_sticky <= 1'b1;
        end
    end

    razor_dvs_window #(
        .WINDOW    (WINDOW),
        .HI_THRESH (HI_THRESH),
        .LO_THRESH (LO_THRESH)
    ) u_dvs_window (
        .clk           (clk),
        .reset         (reset),
        .accept        (accept),
        .vdd_ack       (vdd_ack),
        .vdd_req_valid (vdd_req_valid),
        .vdd_req_up    (vdd_req_up)
    );

endmodule

// File: tb/tb_razor_error_ctrl.sv
// Bench for razor_error_ctrl: two instances (RECOVER_CYCLES 1 and 3) on shared
// inputs, a timeline-level reference model, vector tables and directed corner cases.
module tb_razor_error_ctrl;

    localparam int W   = 32;
    localparam int WIN = 16;
    localparam int HI  = 4;
    localparam int LO  = 0;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  err_in = '0;
    logic          valid_in = 1'b0;
    logic          clr_count = 1'b0;
    logic          vdd_ack = 1'b0;
    logic [1:0]    restore_v, stall_v, replay_v, sticky_v, rv_v, ru_v;
    logic [CW-1:0] cnt_v [2];

    always #5 clk = ~clk;

    razor_error_ctrl #(.WIDTH(W), .RECOVER_CYCLES(1), .WINDOW(WIN), .HI_THRESH(HI),
                       .LO_THRESH(LO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .err_in(err_in), .valid_in(valid_in),
        .clr_count(clr_count), .vdd_ack(vdd_ack), .restore(restore_v[0]),
        .stall(stall_v[0]), .replay(replay_v[0]), .err_count(cnt_v[0]),
        .err_sticky(sticky_v[0]), .vdd_req_valid(rv_v[0]), .vdd_req_up(ru_v[0]));

    razor_error_ctrl #(.WIDTH(W), .RECOVER_CYCLES(3), .WINDOW(WIN), .HI_THRESH(HI),
                       .LO_THRESH(LO), .CNT_W(CW)) dut3 (
        .clk(clk), .reset(reset), .err_in(err_in), .valid_in(valid_in),
        .clr_count(clr_count), .vdd_ack(vdd_ack), .restore(restore_v[1]),
        .stall(stall_v[1]), .replay(replay_v[1]), .err_count(cnt_v[1]),
        .err_sticky(sticky_v[1]), .vdd_req_valid(rv_v[1]), .vdd_req_up(ru_v[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0h, want %0h", name, i, $time, act, exp);
        end
    endtask

    // Reference model: ph = cycles since the accepting edge (0 = idle).
    int ph [2], cnt [2], wpos [2], werr [2];
    bit stk [2], rqv [2], rqu [2];
    bit m_acc, m_dec, m_up;
    int m_total;

    function automatic int rc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                ph[i] = 0; cnt[i] = 0; wpos[i] = 0; werr[i] = 0;
                stk[i] = 0; rqv[i] = 0; rqu[i] = 0;
            end else begin
                m_acc = valid_in && (err_in != '0) && (ph[i] == 0);
                if (m_acc) ph[i] = 1;
                else if (ph[i] != 0) ph[i] = (ph[i] == 2 + rc_of(i)) ? 0 : ph[i] + 1;
                if (clr_count) begin
                    cnt[i] = int'(m_acc);
                    stk[i] = m_acc;
                end else begin
                    cnt[i] = (cnt[i] + int'(m_acc) > CMAX) ? CMAX : cnt[i] + int'(m_acc);
                    stk[i] = stk[i] | m_acc;
                end
                m_dec = 0; m_up = 0;
                if (wpos[i] == WIN - 1) begin
                    m_total = werr[i] + int'(m_acc);
                    if (m_total >= HI) begin m_dec = 1; m_up = 1; end
                    else if (m_total <= LO) m_dec = 1;
                    werr[i] = 0;
                end else begin
                    werr[i] = (werr[i] + int'(m_acc) > 255) ? 255 : werr[i] + int'(m_acc);
                end
                wpos[i] = (wpos[i] + 1) % WIN;
                if (m_dec && (!rqv[i] || vdd_ack)) begin
                    rqv[i] = 1; rqu[i] = m_up;
                end else if (vdd_ack) begin
                    rqv[i] = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("m_restore", i, 32'(restore_v[i]), 32'(ph[i] == 1));
            check("m_stall", i, 32'(stall_v[i]), 32'(ph[i] >= 1 && ph[i] <= 1 + rc_of(i)));
            check("m_replay", i, 32'(replay_v[i]), 32'(ph[i] == 2 + rc_of(i)));
            check("m_count", i, 32'(cnt_v[i]), 32'(cnt[i]));
            check("m_sticky", i, 32'(sticky_v[i]), 32'(stk[i]));
            check("m_req_valid", i, 32'(rv_v[i]), 32'(rqv[i]));
            if (rqv[i]) check("m_req_up", i, 32'(ru_v[i]), 32'(rqu[i]));
        end
    end

    task automatic tick(input logic [W-1:0] e, input logic v, input logic c, input logic a);
        @(negedge clk);
        err_in = e; valid_in = v; clr_count = c; vdd_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_restore"}, i, 32'(restore_v[i]), 0);
            check({tag, "_stall"}, i, 32'(stall_v[i]), 0);
            check({tag, "_replay"}, i, 32'(replay_v[i]), 0);
            check({tag, "_count"}, i, 32'(cnt_v[i]), 0);
            check({tag, "_sticky"}, i, 32'(sticky_v[i]), 0);
            check({tag, "_req_valid"}, i, 32'(rv_v[i]), 0);
            check({tag, "_req_up"}, i, 32'(ru_v[i]), 0);
        end
    endtask

    // Reset asserted mid-cycle; released before the next rising edge (window edge 0).
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        err_in = '0; valid_in = 1'b0; clr_count = 1'b0; vdd_ack = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        #2;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] err;
        logic         valid;
        logic         clr;
        logic         restore;
        logic         stall;
        logic         replay;
        int           cnt;
        logic         sticky;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1]  = '{32'h20,       1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b1};
        tbl[2]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        tbl[3]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1};
        tbl[4]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        tbl[5]  = '{32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        tbl[6]  = '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b1};
        tbl[7]  = '{32'h3,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1};
        tbl[8]  = '{32'h3,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1};
        tbl[9]  = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        tbl[10] = '{32'h8,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1};
        tbl[11] = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        tbl[12] = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1};
        tbl[13] = '{32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        tbl[14] = '{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};

        // Reset held with every error flag raised and a valid instruction.
        reset = 1'b0; err_in = '1; valid_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("release_restore", 0, 32'(restore_v[0]), 1);
        check("release_stall", 0, 32'(stall_v[0]), 1);

        // Continuous errors for a whole window: dut accepts at edges 0,4,8,12.
        repeat (15) tick('1, 1'b1, 1'b0, 1'b0);
        check("dvs_up_valid", 0, 32'(rv_v[0]), 1);
        check("dvs_up_dir", 0, 32'(ru_v[0]), 1);
        check("dvs_mid_none", 1, 32'(rv_v[1]), 0);

        // Quiet window with ack low: the down decision is dropped for dut.
        repeat (16) tick('0, 1'b0, 1'b0, 1'b0);
        check("dvs_drop_valid", 0, 32'(rv_v[0]), 1);
        check("dvs_drop_dir", 0, 32'(ru_v[0]), 1);
        check("dvs_down_valid", 1, 32'(rv_v[1]), 1);
        check("dvs_down_dir", 1, 32'(ru_v[1]), 0);
        tick('0, 1'b0, 1'b0, 1'b1);
        check("dvs_ack_drop", 0, 32'(rv_v[0]), 0);
        check("dvs_ack_drop", 1, 32'(rv_v[1]), 0);

        for (int r = 0; r < 15; r++) begin
            tick(tbl[r].err, tbl[r].valid, tbl[r].clr, 1'b0);
            check("tbl_restore", 0, 32'(restore_v[0]), 32'(tbl[r].restore));
            check("tbl_stall", 0, 32'(stall_v[0]), 32'(tbl[r].stall));
            check("tbl_replay", 0, 32'(replay_v[0]), 32'(tbl[r].replay));
            check("tbl_count", 0, 32'(cnt_v[0]), tbl[r].cnt);
            check("tbl_sticky", 0, 32'(sticky_v[0]), 32'(tbl[r].sticky));
        end

        // Twenty accepted errors against a 4-bit counter.
        repeat (80) tick(32'h1, 1'b1, 1'b0, 1'b0);
        check("count_saturate", 0, 32'(cnt_v[0]), 15);
        repeat (8) tick('0, 1'b0, 1'b0, 1'b0);
        tick(32'h2, 1'b1, 1'b1, 1'b0);
        check("clr_with_accept", 0, 32'(cnt_v[0]), 1);
        check("clr_with_accept", 1, 32'(cnt_v[1]), 1);
        check("sticky_clr_accept", 0, 32'(sticky_v[0]), 1);

        // Reset mid-recovery, then an error-free window gives a down request.
        pulse_reset("abort_recovery");
        repeat (15) tick('0, 1'b0, 1'b0, 1'b0);
        check("down_valid", 0, 32'(rv_v[0]), 1);
        check("down_dir", 0, 32'(ru_v[0]), 0);
        pulse_reset("abort_request");
        repeat (14) tick('0, 1'b0, 1'b0, 1'b0);
        check("win_restart_early", 0, 32'(rv_v[0]), 0);
        tick('0, 1'b0, 1'b0, 1'b0);
        check("win_restart_valid", 0, 32'(rv_v[0]), 1);
        tick('0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("rand_reset");
            end else begin
                tick(($urandom_range(0, 2) == 0) ? W'($urandom) : '0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0);
            end
        end

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
